spi_3wire_readback_capture: RTL

- Receive-side companion to the SPI single-output stage.
- While the output stage has released the shared bidirectional io line (slave_en=1), this block samples the returning serial data on the internally generated clock edges and deserialises it into a parallel word.
- The word is delivered through a valid/ready handshake to the register/readback logic.
- It runs from the same sck_next/cs_next controls the output stage consumes, so no external clock is sampled.

---
 rtl/spi_3wire_readback_capture.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_3wire_readback_capture.sv
// Receive side of the 3-wire SPI stage: samples the returning io line on internally
// generated sck edges, deserialises the bits and hands the word out over valid/ready.
module spi_3wire_readback_capture #(
  parameter int MAX_BITS     = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int SAMPLE_DELAY = 2
) (
  input  logic                CLK100MHZ,
  input  logic                reset_n,
  input  logic                io_in,
  input  logic                slave_en,
  input  logic                cs_next,
  input  logic                sck_next,
  input  logic                sample_edge,
  input  logic                lsb_first,
  input  logic [5:0]          num_bits,
  input  logic                rx_ready,
  input  logic                overrun_clr,
  output logic [MAX_BITS-1:0] rx_data,
  output logic                rx_valid,
  output logic                overrun,
  output logic                busy
);

  localparam int CW = $clog2(MAX_BITS + 1);
  localparam int IW = $clog2(MAX_BITS);
  localparam logic [CW-1:0] MAX_NB  = CW'(MAX_BITS);
  localparam logic [6:0]    MAX_NB7 = 7'(MAX_BITS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   io_sync;
  logic                   sck_prev;
  logic                   edge_ev;
  logic                   sample;
  logic                   dly_busy;
  logic [CW-1:0]          count;
  logic [MAX_BITS-1:0]    shift_reg;
  logic [CW-1:0]          nb_q;
  logic                   lsb_q;

  logic [CW-1:0]          eff_nb;
  logic [CW-1:0]          cur_nb;
  logic                   cur_lsb;
  logic [MAX_BITS-1:0]    shift_nxt;
  logic [IW-1:0]          bit_idx;
  logic                   word_done;
  logic                   abort;

  assign io_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      sck_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], io_in};
      sck_prev <= sck_next;
    end
  end

  // sample_edge=0 selects the 0->1 transition of sck_next, 1 selects 1->0.
  assign edge_ev = slave_en && cs_next && (sck_next != sck_prev) &&
                   (sample_edge ? sck_prev : sck_next);

  generate
    if (SAMPLE_DELAY == 0) begin : g_no_delay
      assign sample   = edge_ev;
      assign dly_busy = 1'b0;
    end else begin : g_delay
      logic [SAMPLE_DELAY-1:0] dly_q;
      if (SAMPLE_DELAY == 1) begin : g_one
        always_ff @(posedge CLK100MHZ or negedge reset_n) begin
          if (!reset_n) dly_q <= '0;
          else          dly_q <= edge_ev;
        end
      end else begin : g_many
        always_ff @(posedge CLK100MHZ or negedge reset_n) begin
          if (!reset_n) dly_q <= '0;
          else          dly_q <= {dly_q[SAMPLE_DELAY-2:0], edge_ev};
        end
      end
      assign sample   = dly_q[SAMPLE_DELAY-1];
      assign dly_busy = |dly_q;
    end
  endgenerate

  // Word format is taken from the ports at the first bit and frozen until the word ends.
  always_comb begin
    eff_nb = CW'(num_bits);
    if (num_bits == 6'd0 || {1'b0, num_bits} > MAX_NB7) eff_nb = MAX_NB;
    cur_nb  = (count == '0) ? eff_nb : nb_q;
    cur_lsb = (count == '0) ? lsb_first : lsb_q;
    bit_idx = count[IW-1:0];
    shift_nxt = shift_reg;
    if (cur_lsb) shift_nxt[bit_idx] = io_sync;
    else         shift_nxt = {shift_reg[MAX_BITS-2:0], io_sync};
    word_done = sample && ((count + CW'(1)) == cur_nb);
    abort     = !cs_next && !dly_busy;
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      shift_reg <= '0;
      nb_q      <= '0;
      lsb_q     <= 1'b0;
    end else if (sample) begin
      if (count == '0) begin
        nb_q  <= eff_nb;
        lsb_q <= lsb_first;
      end
      if (word_done) begin
        count     <= '0;
        shift_reg <= '0;
      end else begin
        count     <= count + CW'(1);
        shift_reg <= shift_nxt;
      end
    end else if (abort) begin
      count     <= '0;
      shift_reg <= '0;
    end
  end

  // Handshake: a word transfers on any edge where rx_valid & rx_ready; rx_valid holds
  // with stable rx_data until then, and a word completing while still unaccepted is dropped.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (word_done && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_nxt;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (word_done && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (overrun_clr)                   overrun <= 1'b0;
    end
  end

  assign busy = (count != '0) || dly_busy;

endmodule
